// File: rtl/systolic_core.sv
// systolic_core: weight-stationary row x col MAC array fed from xmem via L0, drained through OFIFO
// into pmem and a per-column SFP accumulator. Define SFP_RELU_EN to clamp each coreOut column at 0.
module systolic_dly #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_d
);
  if (N == 0) begin : g_wire
    assign o_d = i_d;
  end else begin : g_reg
    logic [W-1:0] r_sh [N];
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < N; k++) r_sh[k] <= '0;
      end else begin
        r_sh[0] <= i_d;
        for (int k = 1; k < N; k++) r_sh[k] <= r_sh[k-1];
      end
    end
    assign o_d = r_sh[N-1];
  end
endmodule

module systolic_fifo #(
  parameter int W  = 8,
  parameter int AW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_qv,
  output logic         o_empty
);
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  logic [W-1:0]  r_mem [2**AW];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_pop, w_push;

  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted then.
  assign w_push  = i_push && ((r_cnt != FULL) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      o_q   <= '0;
      o_qv  <= 1'b0;
    end else begin
      o_qv <= w_pop;
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
        o_q  <= r_mem[r_rp];
      end
      if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end
endmodule

module systolic_core #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int num     = 2048
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [33:0]              inst,
  input  logic [bw*row-1:0]        D_xmem,
  output logic [col*psum_bw-1:0]   coreOut,
  output logic                     valid
);
  logic        w_acc, w_cen_p, w_wen_p, w_cen_x, w_wen_x, w_ofifo_rd;
  logic [10:0] w_a_p, w_a_x;
  logic        w_l0_rd, w_l0_wr, w_exec, w_load;
  assign {w_acc, w_cen_p, w_wen_p, w_a_p, w_cen_x, w_wen_x, w_a_x, w_ofifo_rd} = inst[33:6];
  assign {w_l0_rd, w_l0_wr, w_exec, w_load} = inst[3:0];

  logic [bw*row-1:0]      r_xmem [num];
  logic [bw*row-1:0]      r_xmem_q;
  logic [col*psum_bw-1:0] r_pmem [num];
  logic [col*psum_bw-1:0] r_pmem_q;
  logic [col*psum_bw-1:0] w_ofifo_q, w_ofifo_d;
  logic [bw*row-1:0]      w_l0_q;
  logic                   w_l0_qv, w_l0_empty, w_ofifo_qv, w_ofifo_empty, w_unused;
  logic                   r_l0_wr_d, r_l0_ld, r_l0_ex, r_acc_d;
  logic [col-1:0]         w_col_vld;

  always_ff @(posedge clk) begin
    if (!w_cen_x && !w_wen_x) r_xmem[w_a_x] <= D_xmem;
    if (!w_cen_x && w_wen_x)  r_xmem_q <= r_xmem[w_a_x];
    if (!w_cen_p && !w_wen_p) r_pmem[w_a_p] <= w_ofifo_q;
    if (!w_cen_p && w_wen_p)  r_pmem_q <= r_pmem[w_a_p];
  end

  // l0_wr and acc are delayed one cycle so they line up with the SRAM read issued alongside them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_l0_wr_d, r_l0_ld, r_l0_ex, r_acc_d} <= '0;
    end else begin
      r_l0_wr_d <= w_l0_wr;
      r_acc_d   <= w_acc;
      if (w_l0_rd) begin
        r_l0_ld <= w_load;
        r_l0_ex <= w_exec;
      end
    end
  end

  systolic_fifo #(.W(bw*row), .AW(6)) u_l0 (
    .clk(clk), .reset(reset), .i_push(r_l0_wr_d), .i_pop(w_l0_rd), .i_d(r_xmem_q),
    .o_q(w_l0_q), .o_qv(w_l0_qv), .o_empty(w_l0_empty)
  );

  // Row packet {valid, load, execute, lane}, skewed by row index.
  logic [bw+2:0] w_row_pkt [row];
  for (genvar gi = 0; gi < row; gi++) begin : g_skew
    systolic_dly #(.W(bw+3), .N(gi)) u_dly (
      .clk(clk), .reset(reset),
      .i_d({w_l0_qv, r_l0_ld, r_l0_ex, w_l0_q[bw*gi +: bw]}), .o_d(w_row_pkt[gi])
    );
  end

  logic [bw-1:0]             r_act [row][col];
  logic                      r_av  [row][col];
  logic signed [bw-1:0]      r_w   [row][col];
  logic signed [psum_bw-1:0] r_ps  [row][col];

  for (genvar gi = 0; gi < row; gi++) begin : g_row
    for (genvar gj = 0; gj < col; gj++) begin : g_pe
      logic [bw-1:0]             w_a_in;
      logic                      w_av_in;
      logic signed [bw-1:0]      w_w_in;
      logic signed [psum_bw-1:0] w_ps_in, w_prod;
      if (gj == 0) begin : g_west
        assign w_a_in  = w_row_pkt[gi][bw-1:0];
        assign w_av_in = w_row_pkt[gi][bw+2] & w_row_pkt[gi][bw];
      end else begin : g_inner
        assign w_a_in  = r_act[gi][gj-1];
        assign w_av_in = r_av[gi][gj-1];
      end
      if (gi == 0) begin : g_top
        assign w_ps_in = '0;
      end else begin : g_below
        assign w_ps_in = r_ps[gi-1][gj];
      end
      // Weights enter at the east edge and shift west, so word c settles in column c.
      if (gj == col-1) begin : g_east
        assign w_w_in = w_row_pkt[gi][bw-1:0];
      end else begin : g_shift
        assign w_w_in = r_w[gi][gj+1];
      end
      assign w_prod = $signed({{(psum_bw-bw){1'b0}}, w_a_in})
                    * $signed({{(psum_bw-bw){r_w[gi][gj][bw-1]}}, r_w[gi][gj]});
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_act[gi][gj] <= '0;
          r_av[gi][gj]  <= 1'b0;
          r_w[gi][gj]   <= '0;
          r_ps[gi][gj]  <= '0;
        end else begin
          r_act[gi][gj] <= w_a_in;
          r_av[gi][gj]  <= w_av_in;
          r_ps[gi][gj]  <= w_ps_in + w_prod;
          if (w_row_pkt[gi][bw+2] && w_row_pkt[gi][bw+1]) r_w[gi][gj] <= w_w_in;
        end
      end
    end
  end

  // Column c finishes c cycles after column 0; deskew so one OFIFO word holds one vector.
  for (genvar gi = 0; gi < col; gi++) begin : g_deskew
    logic [psum_bw:0] w_col;
    systolic_dly #(.W(psum_bw+1), .N(col-1-gi)) u_dly (
      .clk(clk), .reset(reset), .i_d({r_av[row-1][gi], r_ps[row-1][gi]}), .o_d(w_col)
    );
    assign w_col_vld[gi] = w_col[psum_bw];
    assign w_ofifo_d[psum_bw*gi +: psum_bw] = w_col[psum_bw-1:0];
  end

  systolic_fifo #(.W(col*psum_bw), .AW(6)) u_ofifo (
    .clk(clk), .reset(reset), .i_push(&w_col_vld), .i_pop(w_ofifo_rd), .i_d(w_ofifo_d),
    .o_q(w_ofifo_q), .o_qv(w_ofifo_qv), .o_empty(w_ofifo_empty)
  );
  assign valid    = !w_ofifo_empty;
  assign w_unused = ^{inst[5:4], w_ofifo_qv, w_l0_empty};

  for (genvar gi = 0; gi < col; gi++) begin : g_sfp
    logic signed [psum_bw-1:0] r_acc;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)       r_acc <= '0;
      else if (r_acc_d) r_acc <= r_acc + $signed(r_pmem_q[psum_bw*gi +: psum_bw]);
    end
`ifdef SFP_RELU_EN
    assign coreOut[psum_bw*gi +: psum_bw] = r_acc[psum_bw-1] ? '0 : r_acc;
`else
    assign coreOut[psum_bw*gi +: psum_bw] = r_acc;
`endif
  end
endmodule

// File: tb/tb_systolic_core.sv
// Directed bench for systolic_core: xmem, weight load, MAC passes, OFIFO, pmem and SFP accumulation.
module tb_systolic_core;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [33:0]  inst;
  logic [31:0]  D_xmem;
  logic [127:0] coreOut;
  logic         valid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] g_w [8];
  logic [31:0] g_a [36];

  systolic_core dut (
    .clk(clk), .reset(rst_n), .inst(inst), .D_xmem(D_xmem), .coreOut(coreOut), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] idle_inst();
    logic [33:0] v = '0;
    v[32] = 1'b1; v[31] = 1'b1; v[19] = 1'b1; v[18] = 1'b1;
    return v;
  endfunction

  function automatic logic [127:0] exp_word(input int k);
    logic [127:0] r;
    int s;
    for (int c = 0; c < 8; c++) begin
      s = 0;
      for (int rr = 0; rr < 8; rr++)
        s += int'($signed(g_w[c][4*rr +: 4])) * int'(g_a[k][4*rr +: 4]);
      r[16*c +: 16] = s[15:0];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [33:0] v);
    inst = v; step(); inst = idle_inst();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; idle(10); rst_n = 1'b1; step();
  endtask

  task automatic xmem_write(input int a, input logic [31:0] d);
    logic [33:0] v = idle_inst();
    v[19] = 1'b0; v[18] = 1'b0; v[17:7] = a[10:0]; D_xmem = d; put(v);
  endtask

  task automatic l0_fill(input int base, input int n);
    logic [33:0] v;
    for (int i = 0; i < n; i++) begin
      int a = base + i;
      v = idle_inst(); v[19] = 1'b0; v[17:7] = a[10:0]; v[2] = 1'b1; put(v);
    end
    idle(2);
  endtask

  task automatic l0_drain(input int n, input logic ld, input logic ex);
    logic [33:0] v = idle_inst();
    v[3] = 1'b1; v[0] = ld; v[1] = ex;
    for (int i = 0; i < n; i++) put(v);
  endtask

  // Two pops past the end of the activations exercise pop-on-empty.
  task automatic run_pass(input int n);
    for (int c = 0; c < 8; c++) xmem_write(1024 + c, g_w[c]);
    for (int k = 0; k < n; k++) xmem_write(k, g_a[k]);
    l0_fill(1024, 8);
    l0_drain(8, 1'b1, 1'b0);
    idle(10);
    l0_fill(0, n);
    l0_drain(n + 2, 1'b0, 1'b1);
    idle(30);
  endtask

  task automatic check_ofifo(input string nm, input int n, input logic use_model,
                             input logic [127:0] const_word);
    logic [33:0] v;
    logic [127:0] e;
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (valid !== 1'b1) begin
        n_fail++; $display("FAIL %s valid k=%0d got %b want 1", nm, k, valid);
      end
      v = idle_inst(); v[6] = 1'b1; put(v);
      e = use_model ? exp_word(k) : const_word;
      n_checks++;
      if (dut.w_ofifo_q !== e) begin
        n_fail++; $display("FAIL %s psum k=%0d got %h want %h", nm, k, dut.w_ofifo_q, e);
      end else $display("ok %s psum k=%0d %h", nm, k, e);
    end
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++; $display("FAIL %s empty got valid=%b want 0", nm, valid);
    end
  endtask

  task automatic pop_to_pmem(input int base, input int n);
    logic [33:0] v;
    for (int k = 0; k < n; k++) begin
      int a = base + k;
      v = idle_inst(); v[6] = 1'b1; put(v);
      v = idle_inst(); v[32] = 1'b0; v[31] = 1'b0; v[30:20] = a[10:0]; put(v);
    end
  endtask

  task automatic accumulate(input int base, input int n);
    logic [33:0] v;
    for (int k = 0; k < n; k++) begin
      int a = base + k;
      v = idle_inst(); v[32] = 1'b0; v[30:20] = a[10:0]; v[33] = 1'b1; put(v);
    end
    idle(3);
  endtask

  task automatic check_core(input string nm, input logic [127:0] e);
    n_checks++;
    if (coreOut !== e) begin
      n_fail++; $display("FAIL %s coreOut got %h want %h", nm, coreOut, e);
    end else $display("ok %s coreOut %h", nm, e);
  endtask

  task automatic check_valid(input string nm, input logic e);
    n_checks++;
    if (valid !== e) begin
      n_fail++; $display("FAIL %s valid got %b want %b", nm, valid, e);
    end else $display("ok %s valid %b", nm, e);
  endtask

  task automatic test_reset();
    do_reset();
    check_valid("reset", 1'b0);
    check_core("reset", '0);
  endtask

  task automatic test_xmem();
    logic [33:0] v;
    for (int k = 0; k < 36; k++) xmem_write(k, 32'hA5000000 + 32'(k) * 32'h00010203);
    foreach (g_a[k]) if (k == 5 || k == 35) begin
      int a = k;
      logic [31:0] e = 32'hA5000000 + 32'(k) * 32'h00010203;
      v = idle_inst(); v[19] = 1'b0; v[17:7] = a[10:0]; put(v);
      n_checks++;
      if (dut.r_xmem_q !== e) begin
        n_fail++; $display("FAIL xmem_rd a=%0d got %h want %h", a, dut.r_xmem_q, e);
      end else $display("ok xmem_rd a=%0d %h", a, e);
    end
  endtask

  task automatic test_ones();
    foreach (g_w[c]) g_w[c] = 32'h11111111;
    foreach (g_a[k]) g_a[k] = 32'h11111111;
    run_pass(36);
    check_ofifo("ones", 36, 1'b0, {8{16'h0008}});
  endtask

  task automatic test_neg_weight();
    foreach (g_w[c]) g_w[c] = (c == 0) ? 32'hFFFFFFFF : 32'h11111111;
    foreach (g_a[k]) g_a[k] = 32'hFFFFFFFF;
    run_pass(4);
    check_ofifo("negw", 4, 1'b0, {{7{16'h0078}}, 16'hFF88});
  endtask

  task automatic test_mixed();
    foreach (g_w[c]) g_w[c] = 32'h8F3A61C5 + 32'(c) * 32'h13579BDF;
    foreach (g_a[k]) g_a[k] = 32'hFEDCBA98 ^ (32'(k) * 32'h0F1E2D3C);
    run_pass(12);
    check_ofifo("mixed", 12, 1'b1, '0);
  endtask

  task automatic test_pmem_acc();
    foreach (g_w[c]) g_w[c] = 32'h00000001;
    foreach (g_a[k]) g_a[k] = 32'h00000003;
    run_pass(9);
    pop_to_pmem(0, 9);
    check_valid("pmem_popped", 1'b0);
    check_core("acc_pre", '0);
    accumulate(0, 9);
    check_core("acc27", {8{16'h001B}});
  endtask

  task automatic test_relu();
    do_reset();
    check_core("acc_cleared", '0);
    foreach (g_w[c]) g_w[c] = 32'h0000000F;
    foreach (g_a[k]) g_a[k] = 32'h00000005;
    run_pass(9);
    pop_to_pmem(16, 9);
    accumulate(16, 9);
`ifdef SFP_RELU_EN
    check_core("neg45", '0);
`else
    check_core("neg45", {8{16'hFFD3}});
`endif
  endtask

  task automatic test_reset_between();
    do_reset();
    check_core("group_reset", '0);
    accumulate(0, 9);
    check_core("pmem_intact", {8{16'h001B}});
    accumulate(16, 9);
`ifdef SFP_RELU_EN
    check_core("mixed_groups", '0);
`else
    check_core("mixed_groups", {8{16'hFFEE}});
`endif
  endtask

  task automatic test_abort();
    foreach (g_a[k]) g_a[k] = 32'h77777777;
    for (int k = 0; k < 8; k++) xmem_write(k, g_a[k]);
    l0_fill(0, 8);
    l0_drain(3, 1'b0, 1'b1);
    do_reset();
    idle(30);
    check_valid("abort", 1'b0);
    check_core("abort", '0);
  endtask

  initial begin
    rst_n  = 1'b0;
    inst   = idle_inst();
    D_xmem = '0;
    test_reset();
    test_xmem();
    test_ones();
    test_neg_weight();
    test_mixed();
    test_pmem_acc();
    test_relu();
    test_reset_between();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
